// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types and constants for the MEM-stage load/store unit
//
// Purpose: FSM state encoding, RV32i load/store funct3 codes and the
// data_to_reg selector value that marks a load writing back memory data.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] DTR_MEM = 2'b01;

endpackage

// File: rtl/mem_access_unit_lsu_align.sv
// rtl/mem_access_unit_lsu_align.sv - byte-lane alignment and load extension for the LSU
//
// Purpose: purely combinational lane logic for byte/half/word accesses.
// Ports:
//   i_funct3     access size/sign code (inst[14:12])
//   i_addr_lo    low two bits of the effective byte address
//   i_store      1 = store, 0 = load
//   i_wdata      store data (rs2)
//   i_rdata      raw read word from the bus
//   o_be         byte enables
//   o_wdata      lane-replicated store data
//   o_load       shifted and sign/zero-extended load result
//   o_illegal    funct3 not valid for this access direction
//   o_misaligned address not naturally aligned for the access size
module lsu_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_store,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load,
  output logic        o_illegal,
  output logic        o_misaligned
);

  logic [31:0] w_shift;

  // Bring the addressed byte/half down to bit 0 before extension.
  assign w_shift = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_be         = 4'b0000;
    o_wdata      = i_wdata;
    o_load       = w_shift;
    o_illegal    = 1'b1;
    o_misaligned = 1'b0;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be      = 4'b0001 << i_addr_lo;
        o_wdata   = {4{i_wdata[7:0]}};
        o_load    = (i_funct3 == F3_BU) ? {24'd0, w_shift[7:0]}
                                        : {{24{w_shift[7]}}, w_shift[7:0]};
        // Unsigned variants only exist for loads.
        o_illegal = i_store && (i_funct3 == F3_BU);
      end
      F3_H, F3_HU: begin
        o_be         = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata      = {2{i_wdata[15:0]}};
        o_load       = (i_funct3 == F3_HU) ? {16'd0, w_shift[15:0]}
                                           : {{16{w_shift[15]}}, w_shift[15:0]};
        o_illegal    = i_store && (i_funct3 == F3_HU);
        o_misaligned = i_addr_lo[0];
      end
      F3_W: begin
        o_be         = 4'hF;
        o_illegal    = 1'b0;
        o_misaligned = |i_addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with single-outstanding data bus
//
// Purpose: issues one byte/half/word access per MEM instruction on a
// req/gnt/rvalid bus, stalls the pipeline until it completes, and reports
// misaligned/illegal accesses and bus timeouts.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   inst_in               instruction in MEM (funct3 = [14:12])
//   ALU_out               effective byte address
//   data_out              store data (rs2)
//   mem_w, data_to_reg    store request / 2'b01 = load
//   pipe_ce               pipeline advance enable
//   dmem_req/we/addr/wdata/be   bus request fields
//   dmem_gnt/rvalid/rdata       bus responses
//   mem_stall             hold upstream registers
//   load_data             registered extended load result
//   access_exc, bus_err   misalign/illegal flag, timeout flag (held in DONE)
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_in,
  input  logic [31:0] ALU_out,
  input  logic [31:0] data_out,
  input  logic        mem_w,
  input  logic [1:0]  data_to_reg,
  input  logic        pipe_ce,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        access_exc,
  output logic        bus_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_load_data;
  logic              r_access_exc, r_bus_err;

  logic              w_acc, w_store, w_bad, w_bus;
  logic              w_req, w_cnt_clr, w_cnt_inc, w_capture, w_timeout;
  logic              w_set_exc, w_clr_flags;
  logic              w_illegal, w_misaligned;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata, w_load;
  logic              w_unused;

  assign w_acc    = mem_w | (data_to_reg == DTR_MEM);
  assign w_store  = mem_w;
  assign w_bad    = w_illegal | w_misaligned;
  assign w_unused = ^{inst_in[31:15], inst_in[11:0]};

  lsu_align u_align (
    .i_funct3     (inst_in[14:12]),
    .i_addr_lo    (ALU_out[1:0]),
    .i_store      (w_store),
    .i_wdata      (data_out),
    .i_rdata      (dmem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load       (w_load),
    .o_illegal    (w_illegal),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_req       = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_set_exc   = 1'b0;
    w_clr_flags = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (w_bad) begin
            w_set_exc = 1'b1;
            w_next    = S_DONE;
          end else begin
            w_req     = 1'b1;
            w_cnt_clr = 1'b1;
            if (dmem_gnt) w_next = w_store ? S_DONE : S_WAIT;
            else          w_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        w_req     = 1'b1;
        w_cnt_inc = 1'b1;
        // A grant on the last allowed cycle still wins over the timeout.
        if (dmem_gnt) begin
          w_next = w_store ? S_DONE : S_WAIT;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_WAIT: begin
        w_cnt_inc = 1'b1;
        if (dmem_rvalid) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        if (pipe_ce) begin
          w_clr_flags = 1'b1;
          w_next      = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_load_data  <= '0;
      r_access_exc <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;

      if (w_capture)      r_load_data <= w_load;
      else if (w_timeout) r_load_data <= '0;

      if (w_set_exc)        r_access_exc <= 1'b1;
      else if (w_clr_flags) r_access_exc <= 1'b0;

      if (w_timeout)        r_bus_err <= 1'b1;
      else if (w_clr_flags) r_bus_err <= 1'b0;
    end
  end

  // Bus fields follow the held EXE/MEM inputs; everything is gated by rst so
  // the bus and stall drop immediately when reset asserts mid-access.
  assign w_bus      = rst & w_req;
  assign dmem_req   = w_bus;
  assign dmem_we    = w_bus & w_store;
  assign dmem_be    = w_bus ? w_be : 4'b0000;
  assign dmem_wdata = w_bus ? w_wdata : 32'd0;
  assign dmem_addr  = w_bus ? {ALU_out[31:2], 2'b00} : 32'd0;
  assign mem_stall  = rst & w_acc & (r_state != S_DONE);

  assign load_data  = r_load_data;
  assign access_exc = r_access_exc;
  assign bus_err    = r_bus_err;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store unit of the RV32i pipeline. Consumes the EXE/MEM pipeline register outputs, performs byte/half/word accesses on a single-outstanding req/gnt/rvalid data bus, and stalls the pipeline until each access completes. Returns aligned, sign- or zero-extended load data to the MEM/WB register and flags misaligned, illegal and timed-out accesses.

## Interface
- TIMEOUT_CYCLES, 255: cycles in REQ or WAIT before the access is abandoned with bus_err.
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-low.
- inst_in  in  32  instruction in MEM; funct3 = inst_in[14:12].
- ALU_out  in  32  effective byte address.
- data_out  in  32  store data (rs2).
- mem_w  in  1  store request.
- data_to_reg  in  2  2'b01 = load result to register.
- pipe_ce  in  1  pipeline advance enable for this cycle.
- dmem_req  out  1  bus request.
- dmem_we  out  1  write strobe, 1 = store.
- dmem_addr  out  32  word address, {ALU_out[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read data.
- mem_stall  out  1  hold upstream registers (upstream CE = !mem_stall).
- load_data  out  32  extended load result, registered.
- access_exc  out  1  misaligned or illegal-funct3 access; stays high while in DONE.
- bus_err  out  1  timeout; stays high while in DONE.

## Operation
- acc = mem_w | (data_to_reg == 2'b01). When both are set, the access is a store.
- Legal funct3 values: 000 B, 001 H, 010 W, 100 BU, 101 HU. BU and HU are illegal for stores. Other codes are illegal.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
- Store lanes:
  - B: wdata = {4{d[7:0]}}, be = 4'b0001 << addr[1:0].
  - H: wdata = {2{d[15:0]}}, be = 4'b0011 << {addr[1],1'b0}.
  - W: wdata = d, be = 4'hF.
- Loads: be as for stores. Shift rdata right by 8·addr[1:0], then sign-extend (B/H) or zero-extend (BU/HU).
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE, acc, illegal or misaligned: no request; access_exc=1; go to DONE.
  - IDLE, acc, legal: dmem_req=1 in the same cycle. On gnt, a store goes to DONE and a load goes to WAIT. Without gnt, go to REQ.
  - REQ: hold dmem_req and all bus fields stable until gnt, then transition as in IDLE.
  - WAIT: on rvalid, capture the extended data into load_data and go to DONE.
  - REQ/WAIT timeout: when the counter reaches TIMEOUT_CYCLES, set bus_err, set load_data=0, go to DONE.
  - DONE: on pipe_ce=1, clear access_exc and bus_err and return to IDLE.
- dmem_rvalid is ignored outside WAIT. A late response after a timeout is dropped.
- mem_stall = acc & (state ≠ DONE). mem_stall is 0 when acc=0.

## Timing
- Store with immediate gnt: 1 stall cycle; DONE on the next cycle.
- Load with immediate gnt and rvalid one cycle later: 2 stall cycles; load_data is valid in DONE, cycle 3.
- Only one access is outstanding. dmem_req is never asserted in WAIT or DONE.
- The timeout counter is 8+ bits wide (clog2(TIMEOUT_CYCLES+1)). It clears on entry to REQ/WAIT from IDLE and does not reset on the REQ→WAIT transition.
- Reset, including mid-access: state=IDLE, counter=0, load_data=0, access_exc=0, bus_err=0. dmem_req, dmem_we, dmem_be, mem_stall and dmem_wdata/dmem_addr are forced to 0 while rst=0, asynchronously. Any in-flight response is discarded.
- DONE with pipe_ce=0: outputs hold; no new request is issued.

## Structure
- Shared package: FSM state enum; funct3 constants F3_B/H/W/BU/HU; DTR_MEM = 2'b01.
- Sub-module lsu_align: combinational; produces be, wdata, the load extraction/extension, and the misalign/illegal flags. The FSM and counter stay in mem_access_unit.

## Test plan
- SW 0xDEADBEEF @0x100, gnt same cycle: one cycle with req=1, we=1, be=F, addr=0x100, stall=1; next cycle stall=0.
- LB @0x103, rdata=0x80xxxxxx, gnt immediate, rvalid +1: load_data=0xFFFFFF80 in DONE. LBU at the same address gives 0x00000080.
- SH 0x1234 @0x202: be=4'b1100, wdata=0x12341234. LH @0x201 gives access_exc=1, no dmem_req, 1 stall cycle.
- LW with gnt delayed 3 cycles: req and addr stable for 4 cycles, stall held until rvalid, then DONE.
- Load with no rvalid, TIMEOUT_CYCLES=4: bus_err=1 after 4 WAIT cycles, load_data=0. A later rvalid is ignored.
- rst=0 asserted in WAIT: dmem_req=0 and stall=0 immediately. After release, state is IDLE and the next LW issues normally.
